// File: rtl/skew_dispatcher_pkg.sv
// skew_dispatcher_pkg
//   Shared definitions for the systolic-array front end: dispatcher state
//   encoding, default datum width and a small sizing helper.
package skew_dispatcher_pkg;

  // Default datum width for the array edges.
  localparam int DISP_DW = 32;

  // State encodings kept as plain constants so older code that compares
  // against raw 2-bit values keeps working.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FEED  = ST_FEED,
    FLUSH = ST_FLUSH,
    DONE  = ST_DONE
  } disp_state_t;

  // Deepest skew line among the A and B edges; sets the flush length.
  function automatic int max_mk(input int m, input int k);
    return (m > k) ? m : k;
  endfunction

endpackage

// File: rtl/skew_dispatcher_skew_line.sv
// skew_line
//   Shift register of DEPTH stages; each stage carries a datum and a valid
//   tag. Stage 0 loads the input, the last stage drives the output.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clr            synchronous clear of every stage
//   shift_en       advance the line by one stage
//   in_vld/in_dat  value loaded into stage 0 on a shift
//   out_vld/out_dat last stage
module skew_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          shift_en,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  output logic [DW-1:0] out_dat
);

  logic [DEPTH-1:0]         vld_q;
  logic [DEPTH-1:0][DW-1:0] dat_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld_q <= '0;
      dat_q <= '0;
    end else if (shift_en) begin
      for (int s = DEPTH - 1; s > 0; s--) begin
        vld_q[s] <= vld_q[s-1];
        dat_q[s] <= dat_q[s-1];
      end
      vld_q[0] <= in_vld;
      dat_q[0] <= in_dat;
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/skew_dispatcher.sv
// skew_dispatcher
//   Pops one column of A and one row of B per step from two FIFOs, delays
//   lane i by i cycles (diagonal skew) and drives the west/north edges of an
//   output-stationary systolic array. done_dispatch is a level that rises
//   once every step and the skew tail have left the edge registers.
//
// Handshake: an entry leaves a FIFO on a rising edge where its pop is high.
//   Pops are asserted only in FEED and only when both FIFOs are non-empty,
//   and always together, so A and B can never drift apart.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse, accepted in IDLE or DONE
//   a_empty/a_dat   A FIFO status and head column (a_dat[i] = A[i][k])
//   a_pop           A FIFO pop
//   b_empty/b_dat   B FIFO status and head row (b_dat[j] = B[k][j])
//   b_pop           B FIFO pop
//   a_edge/b_edge   west/north edge data
//   edge_vld        some edge carries a real (non-bubble) datum
//   busy            FEED or FLUSH
//   done_dispatch   high while in DONE
//   dbg_state       current state encoding
module skew_dispatcher
  import skew_dispatcher_pkg::*;
#(
  parameter int M  = 2,
  parameter int K  = 2,
  parameter int N  = 4,
  parameter int DW = DISP_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 a_empty,
  input  logic [M-1:0][DW-1:0] a_dat,
  output logic                 a_pop,
  input  logic                 b_empty,
  input  logic [K-1:0][DW-1:0] b_dat,
  output logic                 b_pop,
  output logic [M-1:0][DW-1:0] a_edge,
  output logic [K-1:0][DW-1:0] b_edge,
  output logic                 edge_vld,
  output logic                 busy,
  output logic                 done_dispatch,
  output logic [1:0]           dbg_state
);

  localparam int FL = max_mk(M, K);
  localparam int SW = $clog2(N) + 1;
  localparam int FW = $clog2(FL) + 1;

  disp_state_t   state_q;
  logic [SW-1:0] step_ctr;
  logic [FW-1:0] flush_ctr;

  logic feeding;
  logic flushing;
  logic fire;
  logic launch;
  logic shift_en;

  logic [M-1:0] a_vld;
  logic [K-1:0] b_vld;

  assign feeding  = (state_q == FEED);
  assign flushing = (state_q == FLUSH);
  assign fire     = feeding & ~a_empty & ~b_empty;
  assign launch   = start & ((state_q == IDLE) | (state_q == DONE));
  // Lines keep shifting through bubbles so all lanes see the same gaps.
  assign shift_en = feeding | flushing;

  assign a_pop         = fire;
  assign b_pop         = fire;
  assign busy          = feeding | flushing;
  assign done_dispatch = (state_q == DONE);
  assign dbg_state     = state_q;
  assign edge_vld      = (|a_vld) | (|b_vld);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      step_ctr  <= '0;
      flush_ctr <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= FEED;
            step_ctr <= '0;
          end
        end
        FEED: begin
          if (fire) begin
            step_ctr <= step_ctr + SW'(1);
            if (step_ctr == SW'(N - 1)) begin
              state_q   <= FLUSH;
              flush_ctr <= '0;
            end
          end
        end
        FLUSH: begin
          // FL cycles drain the deepest line, so DONE sees all-zero edges.
          if (flush_ctr == FW'(FL - 1)) begin
            state_q <= DONE;
          end else begin
            flush_ctr <= flush_ctr + FW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Lane i of A has i+1 stages; bubbles load zero with a cleared tag.
  for (genvar gi = 0; gi < M; gi++) begin : g_a_line
    skew_line #(.DEPTH(gi + 1), .DW(DW)) u_line (
      .clk      (clk),
      .rst      (rst),
      .clr      (launch),
      .shift_en (shift_en),
      .in_vld   (fire),
      .in_dat   (fire ? a_dat[gi] : '0),
      .out_vld  (a_vld[gi]),
      .out_dat  (a_edge[gi])
    );
  end

  for (genvar gj = 0; gj < K; gj++) begin : g_b_line
    skew_line #(.DEPTH(gj + 1), .DW(DW)) u_line (
      .clk      (clk),
      .rst      (rst),
      .clr      (launch),
      .shift_en (shift_en),
      .in_vld   (fire),
      .in_dat   (fire ? b_dat[gj] : '0),
      .out_vld  (b_vld[gj]),
      .out_dat  (b_edge[gj])
    );
  end

endmodule

// File: tb/tb_skew_dispatcher.sv
// tb_skew_dispatcher
//   Two instances: a 2x2 array with N=4 and an asymmetric 4x2 array with N=1.
//   Cycle 0 of each timeline is the cycle in which start is presented.
module tb_skew_dispatcher;
  import skew_dispatcher_pkg::*;

  localparam int DW  = 32;
  localparam int M0  = 2;
  localparam int K0  = 2;
  localparam int N0  = 4;
  localparam int FL0 = 2;
  localparam int M1  = 4;
  localparam int K1  = 2;
  localparam int N1  = 1;
  localparam int LEN = 40;

  typedef logic [M0-1:0][DW-1:0] acol_t;
  typedef logic [K0-1:0][DW-1:0] bcol_t;
  typedef logic [M1-1:0][DW-1:0] acol1_t;
  typedef logic [K1-1:0][DW-1:0] bcol1_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 0 (2x2, N=4) ----------------
  logic   start0, a_empty0, b_empty0, a_pop0, b_pop0;
  acol_t  a_dat0, a_edge0;
  bcol_t  b_dat0, b_edge0;
  logic   edge_vld0, busy0, done0;
  logic [1:0] state0;

  skew_dispatcher #(.M(M0), .K(K0), .N(N0), .DW(DW)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .a_empty(a_empty0), .a_dat(a_dat0), .a_pop(a_pop0),
    .b_empty(b_empty0), .b_dat(b_dat0), .b_pop(b_pop0),
    .a_edge(a_edge0), .b_edge(b_edge0), .edge_vld(edge_vld0),
    .busy(busy0), .done_dispatch(done0), .dbg_state(state0)
  );

  // ---------------- DUT 1 (4x2, N=1) ----------------
  logic   start1, a_empty1, b_empty1, a_pop1, b_pop1;
  acol1_t a_dat1, a_edge1;
  bcol1_t b_dat1, b_edge1;
  logic   edge_vld1, busy1, done1;
  logic [1:0] state1;

  skew_dispatcher #(.M(M1), .K(K1), .N(N1), .DW(DW)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a_empty(a_empty1), .a_dat(a_dat1), .a_pop(a_pop1),
    .b_empty(b_empty1), .b_dat(b_dat1), .b_pop(b_pop1),
    .a_edge(a_edge1), .b_edge(b_edge1), .edge_vld(edge_vld1),
    .busy(busy1), .done_dispatch(done1), .dbg_state(state1)
  );

  // ---------------- bench state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc;

  acol_t a_fifo[$];
  bcol_t b_fifo[$];
  acol_t a_ref[$];
  bcol_t b_ref[$];

  bit start_at[LEN];
  bit a_stall[LEN];
  bit b_stall[LEN];

  logic [4:0] obs_ctl[LEN];   // {a_pop, b_pop, edge_vld, busy, done}
  acol_t      obs_a[LEN];
  bcol_t      obs_b[LEN];
  logic [1:0] obs_state[LEN];

  bit    exp_pop[LEN];
  bit    exp_vld[LEN];
  bit    exp_busy[LEN];
  bit    exp_done[LEN];
  acol_t exp_a[LEN];
  bcol_t exp_b[LEN];

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    start0 = 1'b0; a_empty0 = 1'b1; b_empty0 = 1'b1; a_dat0 = '0; b_dat0 = '0;
    start1 = 1'b0; a_empty1 = 1'b1; b_empty1 = 1'b1; a_dat1 = '0; b_dat1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    a_fifo.delete(); b_fifo.delete(); a_ref.delete(); b_ref.delete();
    for (int t = 0; t < LEN; t++) begin
      start_at[t] = 1'b0; a_stall[t] = 1'b0; b_stall[t] = 1'b0;
    end
    cyc = 0;
  endtask

  task automatic preload(input int n);
    acol_t a;
    bcol_t b;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < M0; i++) a[i] = DW'($urandom_range(1, 65535));
      for (int j = 0; j < K0; j++) b[j] = DW'($urandom_range(1, 65535));
      a_fifo.push_back(a); a_ref.push_back(a);
      b_fifo.push_back(b); b_ref.push_back(b);
    end
  endtask

  // One cycle of DUT 0: present inputs after the falling edge, sample the
  // outputs 1 time unit later, and pop the FIFO model on a requested pop.
  task automatic drive_cycle();
    @(negedge clk);
    start0   = start_at[cyc];
    a_empty0 = a_stall[cyc] || (a_fifo.size() == 0);
    b_empty0 = b_stall[cyc] || (b_fifo.size() == 0);
    a_dat0   = (a_fifo.size() != 0) ? a_fifo[0] : '0;
    b_dat0   = (b_fifo.size() != 0) ? b_fifo[0] : '0;
    #1;
    obs_ctl[cyc]   = {a_pop0, b_pop0, edge_vld0, busy0, done0};
    obs_a[cyc]     = a_edge0;
    obs_b[cyc]     = b_edge0;
    obs_state[cyc] = state0;
    if (a_pop0 && a_fifo.size() != 0) void'(a_fifo.pop_front());
    if (b_pop0 && b_fifo.size() != 0) void'(b_fifo.pop_front());
    cyc++;
  endtask

  // Reference model: from the start pulses and the empty pattern, list the
  // cycles in which a step is accepted, then place each step's data on the
  // edge of lane i at (accept cycle + i + 1). A run ends N accepted steps
  // plus the deepest lane's drain later.
  task automatic build_model(input int len);
    int cur_done, col, nf, c, last;
    cur_done = -1;
    col = 0;
    for (int t = 0; t < LEN; t++) begin
      exp_pop[t] = 0; exp_vld[t] = 0; exp_busy[t] = 0; exp_done[t] = 0;
      exp_a[t] = '0; exp_b[t] = '0;
    end
    for (int s = 0; s < len; s++) begin
      if (start_at[s] && s >= cur_done) begin
        nf = 0; last = s; c = s + 1;
        for (int t = s + 1; t < len; t++) exp_done[t] = 0;
        while (nf < N0 && c < len) begin
          if (!a_stall[c] && !b_stall[c] && col < a_ref.size()) begin
            exp_pop[c] = 1;
            for (int i = 0; i < M0; i++)
              if (c + i + 1 < len) begin
                exp_a[c+i+1][i] = a_ref[col][i];
                exp_vld[c+i+1] = 1;
              end
            for (int j = 0; j < K0; j++)
              if (c + j + 1 < len) begin
                exp_b[c+j+1][j] = b_ref[col][j];
                exp_vld[c+j+1] = 1;
              end
            col++; nf++; last = c;
          end
          c++;
        end
        cur_done = last + FL0 + 1;
        for (int t = s + 1; t < len && t < cur_done; t++) exp_busy[t] = 1;
        for (int t = cur_done; t < len; t++) exp_done[t] = 1;
      end
    end
  endtask

  task automatic run_timeline(input int len);
    for (int c = 0; c < len; c++) drive_cycle();
    build_model(len);
  endtask

  function automatic int first_done(input int from, input int len);
    for (int c = from; c < len; c++) if (obs_ctl[c][0]) return c;
    return -1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    a_empty0 = 1'b0; b_empty0 = 1'b0; a_dat0 = '1; b_dat0 = '1;
    a_empty1 = 1'b0; b_empty1 = 1'b0; a_dat1 = '1; b_dat1 = '1;
    #1;
    checks++;
    if ({a_pop0, b_pop0, edge_vld0, busy0, done0} !== 5'b0) begin
      failures++; $display("FAIL reset_ctl0 got=%b want=00000", {a_pop0, b_pop0, edge_vld0, busy0, done0});
    end
    checks++;
    if (a_edge0 !== '0 || b_edge0 !== '0) begin
      failures++; $display("FAIL reset_edge0 a=%h b=%h want=0", a_edge0, b_edge0);
    end
    checks++;
    if (state0 !== ST_IDLE || state1 !== ST_IDLE) begin
      failures++; $display("FAIL reset_state got=%0d/%0d want=%0d", state0, state1, ST_IDLE);
    end
    checks++;
    if ({a_pop1, b_pop1, edge_vld1, busy1, done1} !== 5'b0 || a_edge1 !== '0 || b_edge1 !== '0) begin
      failures++; $display("FAIL reset_dut1 ctl=%b a=%h b=%h want=0", {a_pop1, b_pop1, edge_vld1, busy1, done1}, a_edge1, b_edge1);
    end
    a_empty0 = 1'b1; b_empty0 = 1'b1; a_empty1 = 1'b1; b_empty1 = 1'b1;
  endtask

  task automatic test_basic();
    int rise;
    reset_dut();
    preload(N0);
    start_at[0] = 1'b1;
    run_timeline(12);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (obs_ctl[c] !== {exp_pop[c], exp_pop[c], exp_vld[c], exp_busy[c], exp_done[c]}) begin
        failures++; $display("FAIL basic_ctl cyc=%0d got=%b want=%b", c, obs_ctl[c], {exp_pop[c], exp_pop[c], exp_vld[c], exp_busy[c], exp_done[c]});
      end
      checks++;
      if (obs_a[c] !== exp_a[c] || obs_b[c] !== exp_b[c]) begin
        failures++; $display("FAIL basic_edge cyc=%0d a=%h/%h b=%h/%h", c, obs_a[c], exp_a[c], obs_b[c], exp_b[c]);
      end
    end
    rise = first_done(0, 12);
    checks++;
    if (rise != N0 + FL0 + 1) begin
      failures++; $display("FAIL basic_done_rise got=%0d want=%0d", rise, N0 + FL0 + 1);
    end
  endtask

  task automatic test_stall();
    int rise;
    longint unsigned c_obs, c_exp;
    reset_dut();
    preload(N0 + 2);
    start_at[0] = 1'b1;
    b_stall[2] = 1'b1; b_stall[3] = 1'b1; b_stall[4] = 1'b1;
    run_timeline(20);
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (obs_ctl[c] !== {exp_pop[c], exp_pop[c], exp_vld[c], exp_busy[c], exp_done[c]}) begin
        failures++; $display("FAIL stall_ctl cyc=%0d got=%b want=%b", c, obs_ctl[c], {exp_pop[c], exp_pop[c], exp_vld[c], exp_busy[c], exp_done[c]});
      end
      checks++;
      if (obs_a[c] !== exp_a[c] || obs_b[c] !== exp_b[c]) begin
        failures++; $display("FAIL stall_edge cyc=%0d a=%h/%h b=%h/%h", c, obs_a[c], exp_a[c], obs_b[c], exp_b[c]);
      end
    end
    rise = first_done(0, 20);
    checks++;
    if (rise != N0 + FL0 + 1 + 3) begin
      failures++; $display("FAIL stall_done_rise got=%0d want=%0d", rise, N0 + FL0 + 4);
    end
    // Data at a_edge[i] reaches PE(i,j) j cycles later, b_edge[j] i cycles
    // later; a PE multiplies what meets there and accumulates.
    for (int i = 0; i < M0; i++)
      for (int j = 0; j < K0; j++) begin
        c_obs = 0; c_exp = 0;
        for (int c = 0; c < 20; c++)
          if (c - j >= 0 && c - i >= 0)
            c_obs += longint'(obs_a[c-j][i]) * longint'(obs_b[c-i][j]);
        for (int k = 0; k < N0; k++)
          c_exp += longint'(a_ref[k][i]) * longint'(b_ref[k][j]);
        checks++;
        if (c_obs !== c_exp) begin
          failures++; $display("FAIL stall_pe_sum C[%0d][%0d] got=%0d want=%0d", i, j, c_obs, c_exp);
        end
      end
  endtask

  task automatic test_one_empty();
    reset_dut();
    preload(N0 + 2);
    start_at[0] = 1'b1;
    b_stall[1] = 1'b1; b_stall[2] = 1'b1; b_stall[3] = 1'b1;
    run_timeline(16);
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (obs_ctl[c] !== {exp_pop[c], exp_pop[c], exp_vld[c], exp_busy[c], exp_done[c]}) begin
        failures++; $display("FAIL one_empty_ctl cyc=%0d got=%b want=%b", c, obs_ctl[c], {exp_pop[c], exp_pop[c], exp_vld[c], exp_busy[c], exp_done[c]});
      end
      checks++;
      if (obs_a[c] !== exp_a[c] || obs_b[c] !== exp_b[c]) begin
        failures++; $display("FAIL one_empty_edge cyc=%0d a=%h/%h b=%h/%h", c, obs_a[c], exp_a[c], obs_b[c], exp_b[c]);
      end
    end
    checks++;
    if (a_fifo.size() != 2 || b_fifo.size() != 2) begin
      failures++; $display("FAIL one_empty_fifo_left a=%0d b=%0d want=2/2", a_fifo.size(), b_fifo.size());
    end
  endtask

  task automatic test_start_ignored();
    int rise2;
    reset_dut();
    preload(2 * N0);
    start_at[0] = 1'b1;   // accepted from IDLE
    start_at[2] = 1'b1;   // during FEED
    start_at[6] = 1'b1;   // during FLUSH
    start_at[9] = 1'b1;   // during DONE: new run
    run_timeline(22);
    for (int c = 0; c < 22; c++) begin
      checks++;
      if (obs_ctl[c] !== {exp_pop[c], exp_pop[c], exp_vld[c], exp_busy[c], exp_done[c]}) begin
        failures++; $display("FAIL start_ign_ctl cyc=%0d got=%b want=%b", c, obs_ctl[c], {exp_pop[c], exp_pop[c], exp_vld[c], exp_busy[c], exp_done[c]});
      end
      checks++;
      if (obs_a[c] !== exp_a[c] || obs_b[c] !== exp_b[c]) begin
        failures++; $display("FAIL start_ign_edge cyc=%0d a=%h/%h b=%h/%h", c, obs_a[c], exp_a[c], obs_b[c], exp_b[c]);
      end
    end
    checks++;
    if (obs_ctl[9][0] !== 1'b1 || obs_ctl[10][0] !== 1'b0) begin
      failures++; $display("FAIL restart_done_fall done@9=%b done@10=%b want=1/0", obs_ctl[9][0], obs_ctl[10][0]);
    end
    rise2 = first_done(10, 22);
    checks++;
    if (rise2 != 9 + N0 + FL0 + 1) begin
      failures++; $display("FAIL restart_done_rise got=%0d want=%0d", rise2, 9 + N0 + FL0 + 1);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      reset_dut();
      preload(8);
      start_at[0] = 1'b1;
      start_at[$urandom_range(1, 5)] = 1'b1;
      for (int t = 1; t <= 12; t++) begin
        a_stall[t] = ($urandom_range(0, 3) == 0);
        b_stall[t] = ($urandom_range(0, 3) == 0);
      end
      run_timeline(30);
      for (int c = 0; c < 30; c++) begin
        checks++;
        if (obs_ctl[c] !== {exp_pop[c], exp_pop[c], exp_vld[c], exp_busy[c], exp_done[c]}) begin
          failures++; $display("FAIL rand%0d_ctl cyc=%0d got=%b want=%b", it, c, obs_ctl[c], {exp_pop[c], exp_pop[c], exp_vld[c], exp_busy[c], exp_done[c]});
        end
        checks++;
        if (obs_a[c] !== exp_a[c] || obs_b[c] !== exp_b[c]) begin
          failures++; $display("FAIL rand%0d_edge cyc=%0d a=%h/%h b=%h/%h", it, c, obs_a[c], exp_a[c], obs_b[c], exp_b[c]);
        end
      end
    end
  endtask

  task automatic test_rst_flush();
    reset_dut();
    preload(N0);
    start_at[0] = 1'b1;
    for (int c = 0; c < 6; c++) drive_cycle();
    // Cycle 5 is the first FLUSH cycle: step 3 on lane 0, step 2 on lane 1.
    checks++;
    if (obs_ctl[5] !== 5'b00110 || obs_a[5][0] !== a_ref[3][0] || obs_a[5][1] !== a_ref[2][1]) begin
      failures++; $display("FAIL rst_flush_pre ctl=%b want=00110 a=%h", obs_ctl[5], obs_a[5]);
    end
    rst = 1'b1;
    drive_cycle();
    rst = 1'b0;
    checks++;
    if (obs_ctl[6] !== 5'b0 || obs_a[6] !== '0 || obs_b[6] !== '0) begin
      failures++; $display("FAIL rst_flush_clear ctl=%b a=%h b=%h want=0", obs_ctl[6], obs_a[6], obs_b[6]);
    end
    checks++;
    if (obs_state[6] !== ST_IDLE) begin
      failures++; $display("FAIL rst_flush_state got=%0d want=%0d", obs_state[6], ST_IDLE);
    end
  endtask

  task automatic test_asym();
    acol1_t a1, ea;
    bcol1_t b1, eb;
    bit popped;
    logic [4:0] ectl;
    reset_dut();
    for (int i = 0; i < M1; i++) a1[i] = DW'($urandom_range(1, 65535));
    for (int j = 0; j < K1; j++) b1[j] = DW'($urandom_range(1, 65535));
    popped = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start1   = (c == 0);
      a_empty1 = popped;
      b_empty1 = popped;
      a_dat1   = popped ? '0 : a1;
      b_dat1   = popped ? '0 : b1;
      #1;
      // Single pop at cycle 1; lane i shows it at 1 + (i+1); 4-cycle flush.
      ea = '0; eb = '0;
      for (int i = 0; i < M1; i++) if (c == i + 2) ea[i] = a1[i];
      for (int j = 0; j < K1; j++) if (c == j + 2) eb[j] = b1[j];
      ectl = {c == 1, c == 1, (c >= 2 && c <= 5), (c >= 1 && c <= 5), c >= 6};
      checks++;
      if ({a_pop1, b_pop1, edge_vld1, busy1, done1} !== ectl) begin
        failures++; $display("FAIL asym_ctl cyc=%0d got=%b want=%b", c, {a_pop1, b_pop1, edge_vld1, busy1, done1}, ectl);
      end
      checks++;
      if (a_edge1 !== ea || b_edge1 !== eb) begin
        failures++; $display("FAIL asym_edge cyc=%0d a=%h/%h b=%h/%h", c, a_edge1, ea, b_edge1, eb);
      end
      if (a_pop1) popped = 1'b1;
    end
    start1 = 1'b0; a_empty1 = 1'b1; b_empty1 = 1'b1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    start0 = 1'b0; a_empty0 = 1'b1; b_empty0 = 1'b1; a_dat0 = '0; b_dat0 = '0;
    start1 = 1'b0; a_empty1 = 1'b1; b_empty1 = 1'b1; a_dat1 = '0; b_dat1 = '0;
    test_reset();
    test_basic();
    test_stall();
    test_one_empty();
    test_start_ignored();
    test_random();
    test_rst_flush();
    test_asym();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
